// File: rtl/fifo_rptr_empty.sv
// Read-side pointer / empty-flag controller for an async FIFO, clocked in the read domain.
// Latency: a pop updates raddr/rptr_gray/rempty/rlevel at the accepting edge; writes become visible after 2-3 rclk edges.
// Backpressure: rinc is ignored while rempty=1 (no pointer movement, no error).
//
// Ports:
//   rclk, rrst_n       read clock, async active-low reset
//   rinc               read request, qualified internally by ~rempty
//   wptr_gray          write pointer (Gray), asynchronous to rclk, 2-flop synchronised here
//   raddr              RAM read address (low ADDR_SIZE bits of the binary read pointer)
//   rptr_gray          registered Gray read pointer to the write domain
//   rempty             registered empty flag (pessimistic)
//   rlevel             registered occupancy 0..2^ADDR_SIZE; built only when RLEVEL_EN is defined, else tied to 0

// Parameterised Kogge-Stone prefix adder: sum = a + b + cin, modulo 2^W.
module prefix_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  // Column 0 carries cin as a pure generate; column j+1 is bit j.
  localparam int L = $clog2(W + 1);

  logic [W-1:0] p_bit;
  assign p_bit = a ^ b;

  genvar k, j;
  for (k = 0; k <= L; k++) begin : lvl
    logic [W:0] g;
    logic [W:0] p;
    if (k == 0) begin : base
      assign g = {a & b, cin};
      assign p = {p_bit, 1'b0};
    end else begin : merge
      localparam int D = 1 << (k - 1);
      for (j = 0; j <= W; j++) begin : col
        if (j >= D) begin : comb
          assign g[j] = lvl[k-1].g[j] | (lvl[k-1].p[j] & lvl[k-1].g[j-D]);
          assign p[j] = lvl[k-1].p[j] & lvl[k-1].p[j-D];
        end else begin : pass
          assign g[j] = lvl[k-1].g[j];
          assign p[j] = lvl[k-1].p[j];
        end
      end
    end
  end

  // After the last level, column j holds the carry into bit j.
  assign sum = p_bit ^ lvl[L].g[W-1:0];
endmodule

module fifo_rptr_empty #(
  parameter int ADDR_SIZE = 10
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic [ADDR_SIZE:0]   wptr_gray,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr_gray,
  output logic                 rempty,
  output logic [ADDR_SIZE:0]   rlevel
);
  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic          rpop;
  logic          rempty_next;

  assign rpop = rinc & ~rempty;

  prefix_adder #(.W(PW)) u_rptr_inc (
    .a   (rbin),
    .b   ({PW{1'b0}}),
    .cin (rpop),
    .sum (rbin_next)
  );

  assign rgray_next  = (rbin_next >> 1) ^ rbin_next;
  // Full-width compare: wrap bit must match too, otherwise a full FIFO would look empty.
  assign rempty_next = (rgray_next == wq2);
  assign raddr       = rbin[ADDR_SIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      wq1       <= '0;
      wq2       <= '0;
      rempty    <= 1'b1;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      wq1       <= wptr_gray;
      wq2       <= wq1;
      rempty    <= rempty_next;
    end
  end

`ifdef RLEVEL_EN
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] rlevel_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_sync         = '0;
    wbin_sync[PW-1]   = wq2[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin_sync[i] = wbin_sync[i+1] ^ wq2[i];
    end
  end

  // Modulo-2^PW difference; a full FIFO yields exactly 2^ADDR_SIZE.
  assign rlevel_next = wbin_sync - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel <= '0;
    end else begin
      rlevel <= rlevel_next;
    end
  end
`else
  assign rlevel = '0;
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty (ADDR_SIZE=10): directed vector table, wrap/full sequences,
// async reset mid-burst, and a randomized run against a counter-based reference model.
module tb_fifo_rptr_empty;
  localparam int AW  = 10;
  localparam int PW  = AW + 1;
  localparam int MOD = 1 << PW;
  localparam int DEP = 1 << AW;

  logic          rclk;
  logic          rrst_n;
  logic          rinc;
  logic [PW-1:0] wptr_gray;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr_gray;
  logic          rempty;
  logic [PW-1:0] rlevel;

  fifo_rptr_empty #(.ADDR_SIZE(AW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rinc      (rinc),
    .wptr_gray (wptr_gray),
    .raddr     (raddr),
    .rptr_gray (rptr_gray),
    .rempty    (rempty),
    .rlevel    (rlevel)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain counts of words read / written (mod 2^PW).
  int m_rcnt, m_ws1, m_ws2, m_level;
  bit m_empty;
  int w;
  logic [PW-1:0] prev_gray;

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = v[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int exp_lvl(input int v);
`ifdef RLEVEL_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rcnt = 0; m_ws1 = 0; m_ws2 = 0; m_level = 0; m_empty = 1'b1;
    w = 0;
    prev_gray = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rempty"}, int'(rempty), 1);
    check({tag, "_raddr"}, int'(raddr), 0);
    check({tag, "_rptr_gray"}, int'(rptr_gray), 0);
    check({tag, "_rlevel"}, int'(rlevel), 0);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    rinc = 1'b0;
    wptr_gray = '0;
    model_reset();
    #1;
    check_reset_vals("reset");
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // One rclk cycle: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cycle(input bit ri, input int wc);
    int pop;
    rinc = ri;
    wptr_gray = to_gray(wc);
    @(posedge rclk);
    pop = (ri && !m_empty) ? 1 : 0;
    m_rcnt  = (m_rcnt + pop) % MOD;
    m_empty = (m_ws2 == m_rcnt);
    m_level = ((m_ws2 - m_rcnt) % MOD + MOD) % MOD;
    m_ws2 = m_ws1;
    m_ws1 = wc;
    #1;
    check("m_rempty", int'(rempty), int'(m_empty));
    check("m_raddr", int'(raddr), m_rcnt % DEP);
    check("m_rptr_gray", int'(rptr_gray), int'(to_gray(m_rcnt)));
    check("m_rlevel", int'(rlevel), exp_lvl(m_level));
    check("gray_one_bit", ($countones(rptr_gray ^ prev_gray) <= 1) ? 1 : 0, 1);
    prev_gray = rptr_gray;
  endtask

  typedef struct {
    bit rinc;
    int wcnt;
    bit empty;
    int raddr;
    int level;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // Reset, hold rinc; write 3; pop 3; then the last-word pop with a newer wq2.
    for (int i = 0; i < 5; i++) vecs[i] = '{1, 0, 1, 0, 0};
    vecs[5]  = '{0, 3, 1, 0, 0};
    vecs[6]  = '{0, 3, 1, 0, 0};
    vecs[7]  = '{0, 3, 0, 0, 3};
    vecs[8]  = '{1, 3, 0, 1, 2};
    vecs[9]  = '{1, 3, 0, 2, 1};
    vecs[10] = '{1, 3, 1, 3, 0};
    vecs[11] = '{1, 3, 1, 3, 0};
    vecs[12] = '{0, 4, 1, 3, 0};
    vecs[13] = '{0, 4, 1, 3, 0};
    vecs[14] = '{0, 4, 0, 3, 1};
    vecs[15] = '{0, 5, 0, 3, 1};
    vecs[16] = '{0, 5, 0, 3, 1};
    vecs[17] = '{1, 5, 0, 4, 1};
    vecs[18] = '{1, 5, 1, 5, 0};
    vecs[19] = '{0, 5, 1, 5, 0};

    rrst_n = 1'b1;
    rinc = 1'b0;
    wptr_gray = '0;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rinc, vecs[i].wcnt);
      check($sformatf("vec%0d_rempty", i), int'(rempty), int'(vecs[i].empty));
      check($sformatf("vec%0d_raddr", i), int'(raddr), vecs[i].raddr);
      check($sformatf("vec%0d_rlevel", i), int'(rlevel), exp_lvl(vecs[i].level));
    end

    // Wrap: drain up to rbin=1023, then one more word pushes rbin to 1024.
    do_reset();
    for (int i = 0; i < 1040; i++) cycle(1'b1, 1023);
    check("wrap_pre_raddr", int'(raddr), 1023);
    check("wrap_pre_gray", int'(rptr_gray), 11'b01000000000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1024);
    check("wrap_pre_rempty", int'(rempty), 0);
    cycle(1'b1, 1024);
    check("wrap_raddr", int'(raddr), 0);
    check("wrap_gray", int'(rptr_gray), 11'b11000000000);
    check("wrap_rempty", int'(rempty), 1);

    // Full: 1024 words outstanding with rbin=0, then drain completely.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1024);
    check("full_rempty", int'(rempty), 0);
    check("full_rlevel", int'(rlevel), exp_lvl(1024));
    for (int i = 0; i < 1030; i++) cycle(1'b1, 1024);
    check("full_drained_rempty", int'(rempty), 1);
    check("full_drained_raddr", int'(raddr), 0);

    // Randomized traffic with an asynchronous reset dropped in mid-burst.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int occ;
      if (i == 1000) begin
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset_vals("async_mid");
        model_reset();
        wptr_gray = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
      end
      occ = ((w - m_rcnt) % MOD + MOD) % MOD;
      if (occ < DEP && $urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 70 : 30))
        w = (w + 1) % MOD;
      cycle(($urandom_range(0, 99) < 55), w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
